// File: rtl/alu_issue_pipe.sv
// Two-stage issue/writeback pipeline wrapped around a combinational ALU.
// EX drives the ALU from an 8-entry register file with WB forwarding; WB holds the result under backpressure.
module alu_issue_pipe #(
    parameter int NREG = 8,
    parameter int DW   = 8,
    localparam int RW  = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [3:0]    in_ctrl,
    input  logic          in_load,
    input  logic [RW-1:0] in_rd,
    input  logic [RW-1:0] in_rs,
    input  logic [RW-1:0] in_rt,
    input  logic [DW-1:0] in_imm,
    output logic [3:0]    alu_ctrl,
    output logic [DW-1:0] alu_x,
    output logic [DW-1:0] alu_y,
    input  logic [DW-1:0] alu_out,
    input  logic          alu_carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_carry,
    output logic [RW-1:0] out_rd,
    output logic          carry_flag
);

    logic          ex_valid;
    logic [3:0]    ex_ctrl;
    logic          ex_load;
    logic [RW-1:0] ex_rd;
    logic [RW-1:0] ex_rs;
    logic [RW-1:0] ex_rt;
    logic [DW-1:0] ex_imm;

    logic          wb_valid;
    logic [DW-1:0] wb_data;
    logic          wb_carry;
    logic [RW-1:0] wb_rd;
    logic          wb_load;

    logic [DW-1:0] regfile [NREG];

    logic stall;
    logic accept;
    logic retire;

    // r0 is hardwired to zero and never forwarded; otherwise WB wins over the stale register file.
    function automatic logic [DW-1:0] opnd(
        input logic [RW-1:0] idx,
        input logic          fwd_valid,
        input logic [RW-1:0] fwd_rd,
        input logic [DW-1:0] fwd_data,
        input logic [DW-1:0] rf_data
    );
        if (idx == '0)
            return '0;
        else if (fwd_valid && fwd_rd == idx)
            return fwd_data;
        else
            return rf_data;
    endfunction

    assign stall    = wb_valid && !out_ready;
    assign retire   = wb_valid && out_ready;
    assign in_ready = rst_n && !(stall && ex_valid);
    assign accept   = in_valid && in_ready;

    assign alu_ctrl = ex_ctrl;
    assign alu_x    = opnd(ex_rs, wb_valid, wb_rd, wb_data, regfile[ex_rs]);
    assign alu_y    = opnd(ex_rt, wb_valid, wb_rd, wb_data, regfile[ex_rt]);

    assign out_valid = wb_valid;
    assign out_data  = wb_data;
    assign out_carry = wb_carry;
    assign out_rd    = wb_rd;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid   <= 1'b0;
            ex_ctrl    <= '0;
            ex_load    <= 1'b0;
            ex_rd      <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_imm     <= '0;
            wb_valid   <= 1'b0;
            wb_data    <= '0;
            wb_carry   <= 1'b0;
            wb_rd      <= '0;
            wb_load    <= 1'b0;
            carry_flag <= 1'b0;
            // NOTE: the register file is architecturally cleared by reset, so it is built from flops, not a RAM macro.
            for (int i = 0; i < NREG; i++)
                regfile[i] <= '0;
        end else begin
            if (retire) begin
                if (wb_rd != '0)
                    regfile[wb_rd] <= wb_data;
                if (!wb_load)
                    carry_flag <= wb_carry;
            end

            if (!stall) begin
                wb_valid <= ex_valid;
                if (ex_valid) begin
                    wb_data  <= ex_load ? ex_imm : alu_out;
                    wb_carry <= ex_load ? 1'b0 : alu_carry;
                    wb_rd    <= ex_rd;
                    wb_load  <= ex_load;
                end
                ex_valid <= accept;
            end else if (accept) begin
                // EX was empty while WB is stuck; it may still fill.
                ex_valid <= 1'b1;
            end

            if (accept) begin
                ex_ctrl <= in_ctrl;
                ex_load <= in_load;
                ex_rd   <= in_rd;
                ex_rs   <= in_rs;
                ex_rt   <= in_rt;
                ex_imm  <= in_imm;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_pipe.sv
// Self-checking bench for alu_issue_pipe: a sequential-semantics reference model plus
// cycle-level expectations for out_valid/in_ready derived from the two-stage latency rules.
module tb_alu_issue_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_ctrl;
    logic       in_load;
    logic [2:0] in_rd, in_rs, in_rt;
    logic [7:0] in_imm;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic       alu_carry;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_carry;
    logic [2:0] out_rd;
    logic       carry_flag;

    always #5 clk = ~clk;

    // Stand-in for alu_rtl: {carry, out}.
    function automatic logic [8:0] alu_fn(input logic [3:0] c, input logic [7:0] x, input logic [7:0] y);
        case (c)
            4'd0:    alu_fn = {1'b0, x} + {1'b0, y};
            4'd1:    alu_fn = {1'b0, x} - {1'b0, y};
            4'd2:    alu_fn = {1'b0, x & y};
            4'd3:    alu_fn = {1'b0, x | y};
            4'd4:    alu_fn = {1'b0, x ^ y};
            4'd5:    alu_fn = {x, 1'b0};
            default: alu_fn = {1'b0, ~x};
        endcase
    endfunction

    assign {alu_carry, alu_out} = alu_fn(alu_ctrl, alu_x, alu_y);

    alu_issue_pipe dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ctrl   (in_ctrl),
        .in_load   (in_load),
        .in_rd     (in_rd),
        .in_rs     (in_rs),
        .in_rt     (in_rt),
        .in_imm    (in_imm),
        .alu_ctrl  (alu_ctrl),
        .alu_x     (alu_x),
        .alu_y     (alu_y),
        .alu_out   (alu_out),
        .alu_carry (alu_carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry),
        .out_rd    (out_rd),
        .carry_flag(carry_flag)
    );

    typedef struct {
        logic [7:0] data;
        logic       carry;
        logic [2:0] rd;
        bit         ld;
        int         cyc;
    } res_t;

    res_t       q[$];
    logic [7:0] m_reg [8];
    logic       m_flag;
    int         cyc;
    int         rst_edges;
    int         n_assert;
    int         n_fail;
    bit         last_acc;
    bit         prev_stall;
    logic [7:0] prev_data;
    logic       prev_carry;
    logic [2:0] prev_rd;
    bit         alu_chk;
    logic [7:0] alu_ex, alu_ey;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        q.delete();
        for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
        m_flag = 1'b0;
    endtask

    // Sampled on the falling edge, away from the rising edge where state changes.
    task automatic monitor();
        bit         exp_ov;
        bit         exp_ir;
        logic [8:0] r;
        last_acc = 1'b0;
        if (!rst_n) begin
            check("in_ready_in_reset", in_ready, 0);
            if (rst_edges > 0) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_out_data", out_data, 0);
                check("rst_out_carry", out_carry, 0);
                check("rst_out_rd", out_rd, 0);
                check("rst_alu_ctrl", alu_ctrl, 0);
                check("rst_alu_x", alu_x, 0);
                check("rst_alu_y", alu_y, 0);
                check("rst_carry_flag", carry_flag, 0);
            end
            prev_stall = 1'b0;
            return;
        end

        exp_ov = (q.size() > 0) && (q[0].cyc + 2 <= cyc);
        exp_ir = !(exp_ov && !out_ready && q.size() == 2);
        check("out_valid", out_valid, exp_ov);
        check("in_ready", in_ready, exp_ir);
        check("carry_flag", carry_flag, m_flag);
        if (exp_ov) begin
            check("out_data", out_data, q[0].data);
            check("out_carry", out_carry, q[0].carry);
            check("out_rd", out_rd, q[0].rd);
        end
        if (prev_stall) begin
            check("hold_out_data", out_data, prev_data);
            check("hold_out_carry", out_carry, prev_carry);
            check("hold_out_rd", out_rd, prev_rd);
        end
        if (alu_chk) begin
            check("alu_x", alu_x, alu_ex);
            check("alu_y", alu_y, alu_ey);
            alu_chk = 1'b0;
        end

        if (exp_ov && out_ready) begin
            if (!q[0].ld) m_flag = q[0].carry;
            void'(q.pop_front());
        end
        if (in_valid && in_ready) begin
            last_acc = 1'b1;
            if (in_load) r = {1'b0, in_imm};
            else         r = alu_fn(in_ctrl, m_reg[in_rs], m_reg[in_rt]);
            if (in_rd != 3'd0) m_reg[in_rd] = r[7:0];
            q.push_back('{data: r[7:0], carry: (in_load ? 1'b0 : r[8]), rd: in_rd, ld: in_load, cyc: cyc});
        end

        prev_stall = exp_ov && !out_ready;
        prev_data  = out_data;
        prev_carry = out_carry;
        prev_rd    = out_rd;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        if (!rst_n) begin
            clear_model();
            rst_edges++;
        end else begin
            rst_edges = 0;
        end
        #1;
        cyc++;
    endtask

    task automatic drive(input bit v, input logic [3:0] c, input bit ld, input logic [2:0] rd,
                         input logic [2:0] rs, input logic [2:0] rt, input logic [7:0] imm);
        in_valid = v;
        in_ctrl  = c;
        in_load  = ld;
        in_rd    = rd;
        in_rs    = rs;
        in_rt    = rt;
        in_imm   = imm;
    endtask

    task automatic ld(input logic [2:0] rd, input logic [7:0] imm);
        drive(1'b1, 4'd0, 1'b1, rd, 3'd0, 3'd0, imm);
        cycle();
    endtask

    task automatic op(input logic [3:0] c, input logic [2:0] rd, input logic [2:0] rs, input logic [2:0] rt);
        drive(1'b1, c, 1'b0, rd, rs, rt, 8'h00);
        cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
            cycle();
        end
    endtask

    initial begin
        int idx;
        n_assert  = 0;
        n_fail    = 0;
        cyc       = 0;
        rst_edges = 0;
        alu_chk   = 1'b0;
        prev_stall = 1'b0;
        clear_model();

        // Reset held two cycles while an instruction is offered.
        rst_n     = 1'b0;
        out_ready = 1'b1;
        drive(1'b1, 4'd0, 1'b1, 3'd1, 3'd0, 3'd0, 8'hA5);
        cycle();
        cycle();
        rst_n = 1'b1;
        for (int i = 1; i < 8; i++) op(4'd0, 3'(i), 3'(i), 3'd0);
        idle(3);

        // Load + add with forwarding from WB and register-file read.
        ld(3'd1, 8'd3);
        ld(3'd2, 8'd10);
        op(4'd0, 3'd3, 3'd1, 3'd2);
        alu_chk = 1'b1;
        alu_ex  = 8'd3;
        alu_ey  = 8'd10;
        idle(3);

        // Carry out of the adder, then a load that must leave the sticky flag alone.
        ld(3'd1, 8'hFF);
        ld(3'd2, 8'h01);
        op(4'd0, 3'd3, 3'd1, 3'd2);
        ld(3'd4, 8'h55);
        idle(3);
        check("carry_sticky", carry_flag, 1);

        // Dependent chain r1 = r1 + r1, one per cycle.
        ld(3'd1, 8'd1);
        for (int i = 0; i < 4; i++) op(4'd0, 3'd1, 3'd1, 3'd1);
        idle(3);

        // Backpressure: out_ready low for three cycles while three instructions are offered.
        idx = 0;
        for (int k = 0; k < 10; k++) begin
            out_ready = !(k >= 1 && k <= 3);
            case (idx)
                0:       drive(1'b1, 4'd0, 1'b1, 3'd5, 3'd0, 3'd0, 8'h21);
                1:       drive(1'b1, 4'd0, 1'b0, 3'd6, 3'd5, 3'd5, 8'h00);
                2:       drive(1'b1, 4'd4, 1'b0, 3'd7, 3'd6, 3'd5, 8'h00);
                default: drive(1'b0, 4'd0, 1'b0, 3'd0, 3'd0, 3'd0, 8'h00);
            endcase
            cycle();
            if (last_acc) idx++;
        end
        check("bp_all_accepted", idx, 3);
        out_ready = 1'b1;
        idle(2);

        // r0 is never written and never forwarded.
        ld(3'd0, 8'd5);
        op(4'd0, 3'd1, 3'd0, 3'd0);
        idle(3);

        // Reset with two instructions in flight.
        ld(3'd2, 8'd7);
        ld(3'd3, 8'd9);
        out_ready = 1'b0;
        rst_n     = 1'b0;
        drive(1'b1, 4'd0, 1'b1, 3'd4, 3'd0, 3'd0, 8'h33);
        cycle();
        cycle();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        op(4'd0, 3'd2, 3'd2, 3'd0);
        op(4'd0, 3'd3, 3'd3, 3'd0);
        idle(3);

        // Random traffic with random backpressure.
        for (int i = 0; i < 400; i++) begin
            out_ready = ($urandom_range(0, 9) < 7);
            drive($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)), $urandom_range(0, 3) == 0,
                  3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)));
            cycle();
        end

        // Bounded drain.
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() > 0; i++) idle(1);
        check("drain_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_issue_pipe.md
# alu_issue_pipe

Two-stage issue/writeback pipeline sitting directly upstream and downstream of the combinational `alu_rtl`. It accepts instructions over a valid/ready handshake, reads operands from an internal 8×8-bit register file, drives the ALU's `ctrl`/`x`/`y`, then captures `out`/`carry` and writes the result back. It includes same-cycle forwarding and output backpressure, so a stream of dependent ALU operations runs at one instruction per cycle.

## Interface
- `NREG`, 8: register count; index width is 3 bits; r0 reads as 0 and is never written.
- `DW`, 8: datapath width; matches the ALU `x`/`y`/`out`.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `in_valid`  in  1  instruction present.
- `in_ready`  out  1  block can accept; transfer occurs when `in_valid && in_ready` at a rising edge.
- `in_ctrl`  in  4  ALU opcode, passed unmodified to `alu_ctrl`.
- `in_load`  in  1  1 = load immediate: `rd <= in_imm`, ALU result ignored.
- `in_rd`, `in_rs`, `in_rt`  in  3 each  destination, x-source, y-source.
- `in_imm`  in  8  immediate for loads.
- `alu_ctrl`  out  4  to ALU `ctrl`.
- `alu_x`, `alu_y`  out  8 each  to ALU `x`/`y`.
- `alu_out`  in  8  from ALU `out`.
- `alu_carry`  in  1  from ALU `carry`.
- `out_valid`  out  1  retired result present.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  8  result written to `out_rd`.
- `out_carry`  out  1  ALU carry for this result; 0 for loads.
- `out_rd`  out  3  destination index.
- `carry_flag`  out  1  sticky copy of the last retired ALU carry. Loads do not change it.

## Operation
- **EX stage** (registers `ex_valid`, `ex_ctrl`, `ex_load`, `ex_rd`, `ex_rs`, `ex_rt`, `ex_imm`):
  - Loaded from the inputs on each accepted transfer.
  - Drives the ALU combinationally: `alu_ctrl = ex_ctrl`, `alu_x = opnd(ex_rs)`, `alu_y = opnd(ex_rt)`.
- **WB stage** (registers `wb_valid`, `wb_data`, `wb_carry`, `wb_rd`, `wb_load`):
  - Captures from EX when EX advances.
  - `wb_data = ex_load ? ex_imm : alu_out`.
  - `wb_carry = ex_load ? 0 : alu_carry`.
- **Outputs:** `out_valid = wb_valid`; `out_data`/`out_carry`/`out_rd` show the WB registers directly.
- **Retire** = `wb_valid && out_ready`. On retire, at the same edge:
  - `regfile[wb_rd] <= wb_data` if `wb_rd != 0`.
  - `carry_flag <= wb_carry` if `!wb_load`.
- **Operand read `opnd(i)`:**
  - 0 if `i == 0`.
  - Else `wb_data` if `wb_valid && wb_rd == i` (forwarding; applies whether or not WB retires this cycle).
  - Else `regfile[i]`.
- **Stall:** `stall = wb_valid && !out_ready`.
  - While stalled, WB, EX and the ALU inputs hold.
  - `in_ready = rst_n && !(stall && ex_valid)`. EX may still fill if empty.
- **Advance:**
  - When `!stall`, WB takes EX (`wb_valid <= ex_valid`).
  - EX takes the accepted input, else `ex_valid <= 0`.
- Arithmetic is entirely inside the ALU. This block does no width extension; all paths are 8 bits.
- Unused `alu_*` outputs while `ex_valid = 0` hold their last values (don't-care to consumers).

## Timing
- **Reset** (rising edge with `rst_n = 0`):
  - `ex_valid`, `wb_valid`, all EX/WB fields, r1–r7 and `carry_flag` are cleared to 0.
  - `out_valid = 0`, `out_data = 0`, `out_carry = 0`, `out_rd = 0`, `alu_ctrl/x/y = 0`.
  - `in_ready = 0` while `rst_n` is low.
- **Reset mid-operation:** in-flight instructions are discarded and no write occurs at the reset edge.
- **Latency:**
  - Accepted at edge N → drives the ALU during cycle N..N+1.
  - `out_valid` is high after edge N+1.
  - Written into the register file at the first edge with `out_ready = 1`.
- **Throughput:** 1 instruction/cycle with `out_ready` held high.
- **Back-to-back dependency:** instruction B reading A's `rd` is in EX while A is in WB, so it gets `wb_data` by forwarding with no bubble.
- **Simultaneous events:**
  - Retire and forward in the same cycle: the forwarded value equals the written value.
  - Write to r0 is suppressed, and r0 is never forwarded.
- **Backpressure:** a result held in WB stays stable (`out_*` unchanged) until `out_ready`. At most 2 instructions are in flight.

## Test plan
- **Reset:** hold `rst_n = 0` for 2 cycles with `in_valid = 1` → `in_ready = 0`, `out_valid = 0`, all outputs 0. Release, then read r1–r7 via add-with-r0 → every `out_data = 0`.
- **Load + add:**
  - load r1 = 3, load r2 = 10, then add (`ctrl = 0`) r3 = r1 + r2, issued back-to-back with `out_ready = 1`.
  - Expected: `alu_x = 3`, `alu_y = 10` (both forwarded/registered) and `out_data = 13`, `out_rd = 3`, `out_carry = 0`, 2 cycles after issue.
- **Carry:**
  - load r1 = 8'hFF, load r2 = 8'h01, add r3.
  - Expected: `out_data = 8'h00`, `out_carry = 1`, `carry_flag = 1` after retire.
  - A following load leaves `carry_flag = 1`.
- **Dependent chain:** r1 = 1; then r1 = r1 + r1 four times consecutively → results 2, 4, 8, 16 on consecutive cycles, no bubbles.
- **Backpressure:**
  - Drop `out_ready` for 3 cycles while 3 instructions are offered.
  - Expected: `out_*` stable, `in_ready` falls once EX is full, no instruction lost or duplicated, order preserved after `out_ready` returns.
- **r0 and reset mid-flight:**
  - load r0 = 5, then add r1 = r0 + r0 → `out_data = 0`.
  - Assert `rst_n = 0` with 2 instructions in flight → no `out_valid`, and no register is written.
